// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - operand pair fill stage writing packed {op_b, op_a} words into the SRAM A/B pair
//
// Accepts operand pairs over a valid/ready stream and writes each pair as one packed
// word to SRAM port 0, from start_addr_i to end_addr_i inclusive, then pulses done_o.
//
// Optional feature macro: LOADER_CHECKSUM_EN (running XOR of written words on checksum_o).
// Without it checksum_o is tied to 0; the port list is the same in both builds.
//
// Ports:
//   clk_i, rst_ni                clock (rising edge), asynchronous active-low reset
//   start_i                      1-cycle pulse, begins a load when idle
//   start_addr_i, end_addr_i     inclusive write address range, sampled on accepted start
//   in_valid_i, in_ready_o       operand pair stream handshake
//   in_a_i, in_b_i               operands; A -> w_data_o[DATA_W-1:0], B -> upper half
//   write_o, w_addr_o, w_data_o  registered SRAM port-0 write strobe, address, data
//   busy_o                       high while loading
//   done_o                       1-cycle completion pulse
//   err_o                        sticky: last start had end_addr < start_addr
//   count_o                      words written since last accepted start
//   checksum_o                   XOR of written words (zero when feature disabled)
module operand_loader #(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        start_addr_i,
    input  logic [ADDR_W-1:0]        end_addr_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_W-1:0]        in_a_i,
    input  logic [DATA_W-1:0]        in_b_i,
    output logic                     write_o,
    output logic [ADDR_W-1:0]        w_addr_o,
    output logic [MEM_WORD_SIZE-1:0] w_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [ADDR_W:0]          count_o,
    output logic [MEM_WORD_SIZE-1:0] checksum_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   end_addr;
    logic                hs;
    logic                start_ok;

    // in_ready_o is a registered copy of "in LOAD", so it never depends on in_valid_i.
    assign hs       = in_valid_i & in_ready_o;
    assign start_ok = (state == IDLE) && start_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            ptr        <= '0;
            end_addr   <= '0;
            in_ready_o <= 1'b0;
            write_o    <= 1'b0;
            w_addr_o   <= '0;
            w_data_o   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            count_o    <= '0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            write_o <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        count_o <= '0;
                        if (end_addr_i >= start_addr_i) begin
                            ptr        <= start_addr_i;
                            end_addr   <= end_addr_i;
                            err_o      <= 1'b0;
                            in_ready_o <= 1'b1;
                            busy_o     <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            // Empty range: report immediately, write nothing.
                            err_o  <= 1'b1;
                            done_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        write_o  <= 1'b1;
                        w_addr_o <= ptr;
                        w_data_o <= {in_b_i, in_a_i};
                        count_o  <= count_o + 1'b1;
                        if (ptr == end_addr) begin
                            // done_o lands together with the final write strobe.
                            done_o     <= 1'b1;
                            in_ready_o <= 1'b0;
                            busy_o     <= 1'b0;
                            state      <= DONE;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [MEM_WORD_SIZE-1:0] checksum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if ((state == LOAD) && hs) begin
            checksum_q <= checksum_q ^ {in_b_i, in_a_i};
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - self-checking bench for operand_loader against a behavioural load model
module tb_operand_loader;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int MEM_W  = 64;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] start_addr_i = '0;
    logic [ADDR_W-1:0] end_addr_i = '0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_a_i = '0;
    logic [DATA_W-1:0] in_b_i = '0;
    logic              write_o;
    logic [ADDR_W-1:0] w_addr_o;
    logic [MEM_W-1:0]  w_data_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [ADDR_W:0]   count_o;
    logic [MEM_W-1:0]  checksum_o;

    int compared   = 0;
    int mismatched = 0;

    bit          use_dir = 1'b0;
    logic [31:0] dir_a [4];
    logic [31:0] dir_b [4];

    operand_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORD_SIZE(MEM_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i),
        .write_o(write_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .count_o(count_o), .checksum_o(checksum_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ck_exp(input logic [63:0] ck);
`ifdef LOADER_CHECKSUM_EN
        return ck;
`else
        return 64'd0;
`endif
    endfunction

    // One load transaction. The model: the k-th accepted pair lands at address s+k,
    // one cycle after it is accepted; the range holds e-s+1 words; done_o accompanies the last write.
    task automatic do_load(input int s, input int e, input int pct, input bit repulse);
        int          n;
        int          acc;
        int          cyc;
        int          budget;
        bit          pend;
        bit          v;
        int          pend_addr;
        logic [63:0] pend_data;
        logic [63:0] ck;
        logic [31:0] a;
        logic [31:0] b;
        acc = 0; pend = 1'b0; ck = '0; cyc = 0; pend_addr = 0; pend_data = '0;
        @(negedge clk_i);
        start_i = 1'b1; start_addr_i = ADDR_W'(s); end_addr_i = ADDR_W'(e); in_valid_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        if (e < s) begin
            chk("err_done", done_o, 1);
            chk("err_flag", err_o, 1);
            chk("err_count", count_o, 0);
            chk("err_write", write_o, 0);
            chk("err_ready", in_ready_o, 0);
            @(negedge clk_i);
            chk("err_done_drop", done_o, 0);
            chk("err_hold", err_o, 1);
            return;
        end
        n = e - s + 1;
        budget = n * 30 + 50;
        forever begin
            chk("write", write_o, pend);
            if (pend) begin
                chk("w_addr", w_addr_o, 64'(pend_addr));
                chk("w_data", w_data_o, pend_data);
            end
            chk("done", done_o, (pend && acc == n));
            chk("ready", in_ready_o, (acc < n));
            chk("busy", busy_o, (acc < n));
            chk("count", count_o, 64'(acc));
            chk("checksum", checksum_o, ck_exp(ck));
            chk("err_clear", err_o, 0);
            if (pend && acc == n) break;
            if (cyc >= budget) begin
                chk("load_timeout", 64'(acc), 64'(n));
                break;
            end
            start_i = (repulse && cyc == 1);
            if (start_i) begin
                start_addr_i = ADDR_W'(100); end_addr_i = ADDR_W'(200);
            end
            v = ($urandom_range(99) < pct);
            if (use_dir) begin
                a = dir_a[acc % 4]; b = dir_b[acc % 4];
            end else begin
                a = $urandom; b = $urandom;
            end
            in_valid_i = v; in_a_i = a; in_b_i = b;
            pend = v && (acc < n);
            if (pend) begin
                pend_addr = s + acc;
                pend_data = {b, a};
                ck ^= {b, a};
                acc++;
            end
            cyc++;
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk_i);
        chk("post_done", done_o, 0);
        chk("post_write", write_o, 0);
        chk("post_ready", in_ready_o, 0);
        repeat (3) @(negedge clk_i);
        chk("hold_count", count_o, 64'(n));
        chk("hold_checksum", checksum_o, ck_exp(ck));
    endtask

    initial begin
        int s;
        int e;
        #12;
        chk("rst_ready", in_ready_o, 0);
        chk("rst_write", write_o, 0);
        chk("rst_addr", w_addr_o, 0);
        chk("rst_data", w_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_checksum", checksum_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed pairs (1,2)..(7,8) into 0..3, valid every cycle.
        for (int i = 0; i < 4; i++) begin
            dir_a[i] = 32'(2 * i + 1);
            dir_b[i] = 32'(2 * i + 2);
        end
        use_dir = 1'b1;
        do_load(0, 3, 100, 1'b0);
        use_dir = 1'b0;

        // Gappy valid, then an empty range, then recovery from the error.
        do_load(10, 12, 50, 1'b0);
        do_load(5, 4, 100, 1'b0);
        do_load(7, 7, 100, 1'b0);

        // Start re-pulsed mid-load must be ignored.
        do_load(30, 37, 70, 1'b1);

        // Checksum pattern 0xFF ^ 0x0F.
        dir_a[0] = 32'hFF; dir_b[0] = 32'h0;
        dir_a[1] = 32'h0F; dir_b[1] = 32'h0;
        use_dir = 1'b1;
        do_load(20, 21, 100, 1'b0);
        chk("checksum_f0", checksum_o, ck_exp(64'hF0));
        use_dir = 1'b0;

        // Full range.
        do_load(0, 511, 100, 1'b0);

        // Random ranges and valid densities.
        for (int t = 0; t < 6; t++) begin
            s = $urandom_range(511);
            e = s + $urandom_range(20);
            if (e > 511) e = 511;
            do_load(s, e, 30 + $urandom_range(70), ($urandom_range(1) == 1));
        end

        // Reset mid-load after two written words.
        @(negedge clk_i);
        start_i = 1'b1; start_addr_i = 0; end_addr_i = 7;
        @(negedge clk_i);
        start_i = 1'b0; in_valid_i = 1'b1; in_a_i = 32'h11; in_b_i = 32'h22;
        @(negedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        chk("pre_rst_write", write_o, 1);
        chk("pre_rst_count", count_o, 2);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_write", write_o, 0);
        chk("mid_rst_ready", in_ready_o, 0);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_done", done_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("post_rst_done", done_o, 0);
            chk("post_rst_write", write_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
